// File: rtl/tdc_seq_ctrl_if.sv
// Channel-side and FIFO read-port signals of tdc_seq_ctrl.
// master = sequencer, slave = TDC channel plus read consumer.
interface tdc_seq_ctrl_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned RD_W   = 24
);
  logic              tdc_rst;
  logic              tdc_done;
  logic [DATA_W-1:0] tdc_data;
  logic [RD_W-1:0]   rd_data;
  logic              rd_valid;
  logic              rd_ready;

  modport master (
    output tdc_rst, rd_data, rd_valid,
    input  tdc_done, tdc_data, rd_ready
  );

  modport slave (
    input  tdc_rst, rd_data, rd_valid,
    output tdc_done, tdc_data, rd_ready
  );
endinterface

// File: rtl/tdc_seq_ctrl.sv
// Measurement sequencer for one TDC channel: clear, arm, capture into a FWFT FIFO.
// Optional TDC_SEQ_TSTAMP_EN prepends a 16-bit timestamp to every FIFO entry.
module tdc_seq_ctrl #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CLR_CYC = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   irst_n,
  input  logic                   start,
  input  logic                   cont_en,
  input  logic                   abort,
  input  logic                   clr_status,
  tdc_seq_ctrl_if.master         bus,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   overflow,
  output logic [CNT_W-1:0]       meas_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

`ifdef TDC_SEQ_TSTAMP_EN
  localparam int unsigned ENTRY_W = DATA_W + 16;
`else
  localparam int unsigned ENTRY_W = DATA_W;
`endif
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int unsigned TW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StClr, StArm, StCapt} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      clr_cnt_q;
  logic [TW-1:0]      to_cnt_q;
  logic [ENTRY_W-1:0] entry_d, word_q;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        level_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               terr_q, ovf_q;
  logic               clr_last, to_last;
  logic               capture, push_req, to_set, push, pop;

  assign clr_last = (clr_cnt_q == '0);
  assign to_last  = (to_cnt_q == TO_LAST);

  // FSM: state register
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM: next state; abort overrides every other request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start || cont_en) state_d = StClr;
      StClr:  if (clr_last) state_d = StArm;
      StArm: begin
        if (bus.tdc_done)  state_d = StCapt;
        else if (to_last)  state_d = cont_en ? StClr : StIdle;
      end
      StCapt: state_d = cont_en ? StClr : StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // FSM: outputs; the channel is only out of reset while armed and not aborting
  always_comb begin
    bus.tdc_rst = 1'b1;
    capture     = 1'b0;
    push_req    = 1'b0;
    to_set      = 1'b0;
    unique case (state_q)
      StArm: begin
        bus.tdc_rst = abort;
        capture     = bus.tdc_done && !abort;
        to_set      = to_last && !bus.tdc_done && !abort;
      end
      StCapt:  push_req = !abort;
      default: ;
    endcase
  end

  assign pop  = bus.rd_valid && bus.rd_ready;
  assign push = push_req && ((level_q != FULL_LVL) || pop);

`ifdef TDC_SEQ_TSTAMP_EN
  logic [15:0] ts_q;

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n)         ts_q <= '0;
    else if (clr_status) ts_q <= '0;
    else                 ts_q <= ts_q + 16'd1;
  end

  assign entry_d = {ts_q, bus.tdc_data};
`else
  assign entry_d = bus.tdc_data;
`endif

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      clr_cnt_q <= CLR_LOAD;
      to_cnt_q  <= '0;
      word_q    <= '0;
    end else begin
      clr_cnt_q <= (state_q == StClr) ? clr_cnt_q - 1'b1 : CLR_LOAD;
      to_cnt_q  <= (state_q == StArm) ? to_cnt_q + 1'b1 : '0;
      if (capture) word_q <= entry_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_q;
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  // Set/increment events win over a simultaneous clr_status
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (clr_status) cnt_q <= push ? CNT_W'(1) : '0;
      else if (push)  cnt_q <= cnt_q + 1'b1;
      if (to_set)          terr_q <= 1'b1;
      else if (clr_status) terr_q <= 1'b0;
      if (push_req && !push) ovf_q <= 1'b1;
      else if (clr_status)   ovf_q <= 1'b0;
    end
  end

  assign bus.rd_valid = (level_q != '0);
  assign bus.rd_data  = bus.rd_valid ? mem_q[rd_ptr_q] : '0;
  assign busy         = (state_q != StIdle);
  assign timeout_err  = terr_q;
  assign overflow     = ovf_q;
  assign meas_cnt     = cnt_q;
  assign fifo_level   = level_q;

endmodule

// File: doc/tdc_seq_ctrl.md
Name: tdc_seq_ctrl

Overview:
- Measurement sequencer for one TDC channel (decoder plus merging stage).
- Holds the channel in reset while idle, releases (arms) it on request, and waits for the merging stage's single-cycle done pulse.
- Captures the merged output word into a small FWFT FIFO with a valid/ready read port.
- Supervises timeouts and overflow, and supports single-shot or continuous re-arming.

Parameters:
- DATA_W, 24, width of merged TDC word; must equal `DIG_OUT.
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- CLR_CYC, 4, cycles tdc_rst is held before arming; at least 1.
- TIMEOUT, 1024, max ARM cycles before abort; at least 2.
- CNT_W, 16, width of meas_cnt.

Ports:
- clk  in  1  system clock; same clock as the merging stage.
- irst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to take one measurement.
- cont_en  in  1  level; continuous mode, re-arms automatically.
- abort  in  1  synchronous; returns to IDLE from any state.
- clr_status  in  1  clears timeout_err, overflow, meas_cnt.
- tdc_done  in  1  single-cycle done pulse from the merging stage.
- tdc_data  in  DATA_W  merged word; valid in the tdc_done cycle.
- tdc_rst  out  1  drives the channel's irst; active high.
- rd_data  out  DATA_W  FIFO head (see Optional Feature).
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts the head word.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  sticky.
- overflow  out  1  sticky.
- meas_cnt  out  CNT_W  count of words accepted into the FIFO; wraps.
- fifo_level  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values (irst_n low, asynchronous):
  - State = IDLE; tdc_rst = 1.
  - busy, rd_valid, timeout_err, overflow = 0.
  - meas_cnt = 0, fifo_level = 0, FIFO pointers = 0, rd_data = 0.
- States: IDLE, CLR, ARM, CAPT.
- IDLE:
  - tdc_rst = 1.
  - start = 1 or cont_en = 1 -> CLR next cycle, clear counter loaded.
- CLR:
  - tdc_rst = 1 for exactly CLR_CYC cycles, then -> ARM.
  - Timeout counter zeroed on entry to ARM.
- ARM:
  - tdc_rst = 0; timeout counter increments each cycle.
  - tdc_done = 1 -> CAPT, with tdc_data registered that cycle.
  - Counter reaches TIMEOUT-1 without done -> set timeout_err; go to CLR if cont_en, else IDLE.
  - tdc_done in the same cycle as expiry: done wins, no timeout_err.
- CAPT (one cycle):
  - tdc_rst = 1.
  - Push the registered word if fifo_level < DEPTH or a pop occurs in the same cycle; on push, meas_cnt += 1.
  - Otherwise drop the word and set overflow.
  - Next state: CLR if cont_en, else IDLE.
- tdc_done outside ARM is ignored.
- start while busy is ignored.
- cont_en deasserted mid-sequence: the current measurement completes, then the block returns to IDLE.
- abort: from any state -> IDLE next cycle; tdc_rst = 1 that cycle; an in-flight word is discarded; FIFO contents are kept.
- abort has priority over tdc_done and start in the same cycle.
- Latency:
  - start at cycle 0 -> tdc_rst released at cycle 1+CLR_CYC.
  - tdc_done at cycle t -> CAPT at t+1 -> rd_valid at t+2 if the FIFO was empty.
- FIFO:
  - First-word-fall-through; rd_data = head word; pop when rd_valid & rd_ready.
  - Pointers wrap modulo DEPTH.
  - fifo_level updates: +1 push only, -1 pop only, unchanged on simultaneous push and pop.
  - Pop on empty has no effect.
- Status:
  - clr_status clears the sticky flags and meas_cnt.
  - A set or increment event in the same cycle wins: the flag stays 1, meas_cnt becomes 1.
- busy is registered and equals (state != IDLE).

Optional Feature:
- Macro: TDC_SEQ_TSTAMP_EN.
- Defined:
  - A 16-bit free-running timestamp counter (reset 0, wraps) is sampled in the tdc_done cycle.
  - Each FIFO entry is {timestamp[15:0], word}; rd_data width is DATA_W+16.
  - The counter is cleared by clr_status.
- Undefined:
  - No timestamp counter; entries and rd_data are DATA_W wide.

Test Plan:
- Reset, then idle 10 cycles -> tdc_rst = 1, busy = 0, rd_valid = 0, fifo_level = 0.
- start pulse, tdc_done with tdc_data = 0x00ABCD 20 cycles after tdc_rst falls (CLR_CYC = 4) -> tdc_rst high cycles 1-4, rd_valid 2 cycles after done, rd_data = 0x00ABCD, meas_cnt = 1, state IDLE.
- cont_en = 1, 10 done pulses, rd_ready = 0, DEPTH = 8 -> fifo_level = 8, overflow = 1, meas_cnt = 8; drain with rd_ready = 1 -> first 8 words in order.
- start, no done, TIMEOUT = 16 -> timeout_err = 1 after 16 ARM cycles, state IDLE; clr_status -> timeout_err = 0.
- tdc_done coincident with the final timeout cycle -> word captured, timeout_err = 0.
- abort in ARM with tdc_done the same cycle -> IDLE next cycle, no push, meas_cnt unchanged; irst_n low mid-CAPT -> all outputs at reset values immediately.
